// File: rtl/id_stage_reg.sv
// ID/EX pipeline register: captures decoded control, operands, immediates, dest and PC.
// Priority per edge: async reset > flush (bubble) > freeze (hold) > load.
// Optional forwarding-source fields are enabled by defining ID_STAGE_FWD_SRC_EN.
module id_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              valid_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic              imm_in,
  input  logic              c_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [REG_AW-1:0] dest_in,
`ifdef ID_STAGE_FWD_SRC_EN
  input  logic [REG_AW-1:0] src1_in,
  input  logic [REG_AW-1:0] src2_in,
  input  logic              use_src2_in,
  output logic [REG_AW-1:0] src1_out,
  output logic [REG_AW-1:0] src2_out,
  output logic              use_src2_out,
`endif
  output logic              valid_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic [3:0]        exe_cmd_out,
  output logic              imm_out,
  output logic              c_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [REG_AW-1:0] dest_out
);

  logic              valid_q, valid_d;
  logic              wb_en_q, wb_en_d;
  logic              mem_r_en_q, mem_r_en_d;
  logic              mem_w_en_q, mem_w_en_d;
  logic              b_q, b_d;
  logic              s_q, s_d;
  logic [3:0]        exe_cmd_q, exe_cmd_d;
  logic              imm_q, imm_d;
  logic              c_q, c_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] val_rn_q, val_rn_d;
  logic [DATA_W-1:0] val_rm_q, val_rm_d;
  logic [11:0]       shift_operand_q, shift_operand_d;
  logic [23:0]       signed_imm_24_q, signed_imm_24_d;
  logic [REG_AW-1:0] dest_q, dest_d;
`ifdef ID_STAGE_FWD_SRC_EN
  logic [REG_AW-1:0] src1_q, src1_d;
  logic [REG_AW-1:0] src2_q, src2_d;
  logic              use_src2_q, use_src2_d;
`endif

  always_comb begin
    valid_d         = valid_q;
    wb_en_d         = wb_en_q;
    mem_r_en_d      = mem_r_en_q;
    mem_w_en_d      = mem_w_en_q;
    b_d             = b_q;
    s_d             = s_q;
    exe_cmd_d       = exe_cmd_q;
    imm_d           = imm_q;
    c_d             = c_q;
    pc_d            = pc_q;
    val_rn_d        = val_rn_q;
    val_rm_d        = val_rm_q;
    shift_operand_d = shift_operand_q;
    signed_imm_24_d = signed_imm_24_q;
    dest_d          = dest_q;
`ifdef ID_STAGE_FWD_SRC_EN
    src1_d          = src1_q;
    src2_d          = src2_q;
    use_src2_d      = use_src2_q;
`endif
    if (flush) begin
      // Flush wins over freeze: the slot becomes a full, side-effect-free bubble.
      valid_d         = 1'b0;
      wb_en_d         = 1'b0;
      mem_r_en_d      = 1'b0;
      mem_w_en_d      = 1'b0;
      b_d             = 1'b0;
      s_d             = 1'b0;
      exe_cmd_d       = 4'b0000;
      imm_d           = 1'b0;
      c_d             = 1'b0;
      pc_d            = '0;
      val_rn_d        = '0;
      val_rm_d        = '0;
      shift_operand_d = '0;
      signed_imm_24_d = '0;
      dest_d          = '0;
`ifdef ID_STAGE_FWD_SRC_EN
      src1_d          = '0;
      src2_d          = '0;
      use_src2_d      = 1'b0;
`endif
    end else if (!freeze) begin
      // Side-effecting control is gated by valid_in; data fields load as-is.
      valid_d         = valid_in;
      wb_en_d         = wb_en_in    & valid_in;
      mem_r_en_d      = mem_r_en_in & valid_in;
      mem_w_en_d      = mem_w_en_in & valid_in;
      b_d             = b_in        & valid_in;
      s_d             = s_in        & valid_in;
      exe_cmd_d       = exe_cmd_in;
      imm_d           = imm_in;
      c_d             = c_in;
      pc_d            = pc_in;
      val_rn_d        = val_rn_in;
      val_rm_d        = val_rm_in;
      shift_operand_d = shift_operand_in;
      signed_imm_24_d = signed_imm_24_in;
      dest_d          = dest_in;
`ifdef ID_STAGE_FWD_SRC_EN
      src1_d          = src1_in;
      src2_d          = src2_in;
      use_src2_d      = use_src2_in & valid_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q         <= 1'b0;
      wb_en_q         <= 1'b0;
      mem_r_en_q      <= 1'b0;
      mem_w_en_q      <= 1'b0;
      b_q             <= 1'b0;
      s_q             <= 1'b0;
      exe_cmd_q       <= 4'b0000;
      imm_q           <= 1'b0;
      c_q             <= 1'b0;
      pc_q            <= '0;
      val_rn_q        <= '0;
      val_rm_q        <= '0;
      shift_operand_q <= '0;
      signed_imm_24_q <= '0;
      dest_q          <= '0;
`ifdef ID_STAGE_FWD_SRC_EN
      src1_q          <= '0;
      src2_q          <= '0;
      use_src2_q      <= 1'b0;
`endif
    end else begin
      valid_q         <= valid_d;
      wb_en_q         <= wb_en_d;
      mem_r_en_q      <= mem_r_en_d;
      mem_w_en_q      <= mem_w_en_d;
      b_q             <= b_d;
      s_q             <= s_d;
      exe_cmd_q       <= exe_cmd_d;
      imm_q           <= imm_d;
      c_q             <= c_d;
      pc_q            <= pc_d;
      val_rn_q        <= val_rn_d;
      val_rm_q        <= val_rm_d;
      shift_operand_q <= shift_operand_d;
      signed_imm_24_q <= signed_imm_24_d;
      dest_q          <= dest_d;
`ifdef ID_STAGE_FWD_SRC_EN
      src1_q          <= src1_d;
      src2_q          <= src2_d;
      use_src2_q      <= use_src2_d;
`endif
    end
  end

  assign valid_out         = valid_q;
  assign wb_en_out         = wb_en_q;
  assign mem_r_en_out      = mem_r_en_q;
  assign mem_w_en_out      = mem_w_en_q;
  assign b_out             = b_q;
  assign s_out             = s_q;
  assign exe_cmd_out       = exe_cmd_q;
  assign imm_out           = imm_q;
  assign c_out             = c_q;
  assign pc_out            = pc_q;
  assign val_rn_out        = val_rn_q;
  assign val_rm_out        = val_rm_q;
  assign shift_operand_out = shift_operand_q;
  assign signed_imm_24_out = signed_imm_24_q;
  assign dest_out          = dest_q;
`ifdef ID_STAGE_FWD_SRC_EN
  assign src1_out          = src1_q;
  assign src2_out          = src2_q;
  assign use_src2_out      = use_src2_q;
`endif

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed bench for id_stage_reg: reset, load, freeze, flush, bubble input, negedge writeback.
module tb_id_stage_reg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  logic              clk;
  logic              rst;
  logic              flush, freeze, valid_in;
  logic              wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
  logic [3:0]        exe_cmd_in;
  logic              imm_in, c_in;
  logic [DATA_W-1:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm_24_in;
  logic [REG_AW-1:0] dest_in;
  logic              valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
  logic [3:0]        exe_cmd_out;
  logic              imm_out, c_out;
  logic [DATA_W-1:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0]       shift_operand_out;
  logic [23:0]       signed_imm_24_out;
  logic [REG_AW-1:0] dest_out;
`ifdef ID_STAGE_FWD_SRC_EN
  logic [REG_AW-1:0] src1_in, src2_in, src1_out, src2_out;
  logic              use_src2_in, use_src2_out;
`endif

  logic [DATA_W-1:0] rf [16];

  int n_checks = 0;
  int n_errors = 0;

  id_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .imm_in(imm_in), .c_in(c_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in),
`ifdef ID_STAGE_FWD_SRC_EN
    .src1_in(src1_in), .src2_in(src2_in), .use_src2_in(use_src2_in),
    .src1_out(src1_out), .src2_out(src2_out), .use_src2_out(use_src2_out),
`endif
    .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out),
    .exe_cmd_out(exe_cmd_out), .imm_out(imm_out), .c_out(c_out), .pc_out(pc_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_zero();
    flush = 0; freeze = 0; valid_in = 0;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0;
    exe_cmd_in = 4'h0; imm_in = 0; c_in = 0;
    pc_in = '0; val_rn_in = '0; val_rm_in = '0;
    shift_operand_in = '0; signed_imm_24_in = '0; dest_in = '0;
`ifdef ID_STAGE_FWD_SRC_EN
    src1_in = '0; src2_in = '0; use_src2_in = 0;
`endif
  endtask

  task automatic drive_all_ones();
    valid_in = 1; wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; b_in = 1; s_in = 1;
    exe_cmd_in = 4'hF; imm_in = 1; c_in = 1;
    pc_in = 32'hFFFF_FFF0; val_rn_in = 32'h1234_5678; val_rm_in = 32'h9ABC_DEF0;
    shift_operand_in = 12'hABC; signed_imm_24_in = 24'h7F_FFFF; dest_in = 4'hE;
`ifdef ID_STAGE_FWD_SRC_EN
    src1_in = 4'h7; src2_in = 4'h9; use_src2_in = 1;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    logic [63:0] agg;
    agg = {63'd0, valid_out | wb_en_out | mem_r_en_out | mem_w_en_out | b_out | s_out
           | imm_out | c_out | (|exe_cmd_out) | (|pc_out) | (|val_rn_out) | (|val_rm_out)
           | (|shift_operand_out) | (|signed_imm_24_out) | (|dest_out)
`ifdef ID_STAGE_FWD_SRC_EN
           | (|src1_out) | (|src2_out) | use_src2_out
`endif
          };
    check(tag, agg, 64'd0);
  endtask

  initial begin
    rst = 0;
    drive_zero();
    repeat (2) tick();
    check_all_zero("reset_idle");
    rst = 1;

    // Load nonzero state, then assert reset mid-cycle
    drive_all_ones();
    tick();
    check("preload_pc", pc_out, 64'hFFFF_FFF0);
    check("preload_valid", valid_out, 1);
    #2 rst = 0;
    #1 check_all_zero("async_reset");
    check("async_reset_exe_cmd", exe_cmd_out, 0);

    // Release: first edge with rst=1 loads
    drive_zero();
    pc_in = 32'h0000_0004;
    valid_in = 1;
    #1 rst = 1;
    tick();
    check("release_pc", pc_out, 32'h4);
    check("release_valid", valid_out, 1);

    // Load test
    drive_zero();
    valid_in = 1; wb_en_in = 1; exe_cmd_in = 4'b0010;
    val_rn_in = 32'h0000_000A; val_rm_in = 32'h0000_0005; dest_in = 4'd3;
    shift_operand_in = 12'h123; signed_imm_24_in = 24'h80_0001; imm_in = 1; c_in = 1;
    tick();
    check("load_valid", valid_out, 1);
    check("load_wb_en", wb_en_out, 1);
    check("load_exe_cmd", exe_cmd_out, 4'b0010);
    check("load_val_rn", val_rn_out, 32'hA);
    check("load_val_rm", val_rm_out, 32'h5);
    check("load_dest", dest_out, 3);
    check("load_shift_op", shift_operand_out, 12'h123);
    check("load_simm24", signed_imm_24_out, 24'h80_0001);
    check("load_imm_c", {imm_out, c_out}, 2'b11);

    // Freeze for 3 edges
    drive_zero();
    valid_in = 1; mem_r_en_in = 1; pc_in = 32'h10;
    tick();
    check("frz_load_pc", pc_out, 32'h10);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'h14 + 32'(4 * i);
      mem_r_en_in = 0;
      valid_in = 0;
      tick();
      check("frz_hold_pc", pc_out, 32'h10);
      check("frz_hold_ctl", {valid_out, mem_r_en_out}, 2'b11);
    end
    freeze = 0;
    tick();
    check("frz_release_pc", pc_out, 32'h1C);
    check("frz_release_valid", valid_out, 0);

    // Reset asserted mid-freeze
    drive_all_ones();
    tick();
    freeze = 1;
    #2 rst = 0;
    #1 check_all_zero("reset_mid_freeze");
    #1 rst = 1;
    freeze = 0;

    // Flush priority over freeze, and back-to-back flush
    drive_all_ones();
    tick();
    check("pre_flush_dest", dest_out, 4'hE);
    flush = 1; freeze = 1; valid_in = 1; mem_w_en_in = 1; dest_in = 4'd5; pc_in = 32'h20;
    tick();
    check("flush_valid", valid_out, 0);
    check("flush_mem_w", mem_w_en_out, 0);
    check("flush_dest", dest_out, 0);
    check("flush_pc", pc_out, 0);
    check_all_zero("flush_all");
    freeze = 0;
    tick();
    check_all_zero("flush_b2b");
    flush = 0;

    // Bubble input: control gated, data loads
    drive_zero();
    valid_in = 0; wb_en_in = 1; s_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; b_in = 1;
    val_rn_in = 32'h55; pc_in = 32'h40;
`ifdef ID_STAGE_FWD_SRC_EN
    src1_in = 4'd2; use_src2_in = 1;
`endif
    tick();
    check("bubble_wb_en", wb_en_out, 0);
    check("bubble_s", s_out, 0);
    check("bubble_mem_b", {mem_r_en_out, mem_w_en_out, b_out}, 3'b000);
    check("bubble_valid", valid_out, 0);
    check("bubble_val_rn", val_rn_out, 32'h55);
    check("bubble_pc", pc_out, 32'h40);
`ifdef ID_STAGE_FWD_SRC_EN
    check("bubble_src1", src1_out, 2);
    check("bubble_use_src2", use_src2_out, 0);
`endif

    // Negedge writeback visible at the following rising edge
    drive_zero();
    for (int i = 0; i < 16; i++) rf[i] = 32'(i * 16);
    valid_in = 1; wb_en_in = 1; dest_in = 4'd4;
    val_rn_in = rf[3];
    val_rm_in = rf[2];
`ifdef ID_STAGE_FWD_SRC_EN
    src1_in = 4'd3; src2_in = 4'd2; use_src2_in = 1;
`endif
    @(negedge clk);
    rf[3] = 32'hDEAD_BEEF;
    val_rn_in = rf[3];
    tick();
    check("negedge_wb_rn", val_rn_out, 32'hDEAD_BEEF);
    check("negedge_wb_rm", val_rm_out, 32'h20);
`ifdef ID_STAGE_FWD_SRC_EN
    check("fwd_src1", src1_out, 3);
    check("fwd_src2", src2_out, 2);
    check("fwd_use_src2", use_src2_out, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
